ahb_mem_slave: RTL and testbench
================================

# ahb_mem_slave

Parametrised AHB-Lite slave model for the axi2ahb verification environment. Unlike a pattern-only responder, it backs transfers with a word-addressed memory, honours HSIZE byte lanes and generates deterministic LFSR-driven wait states. It signals ERROR responses for a programmable address window and for illegal sizes or alignments, and keeps transfer and error counters for scoreboard cross-checks.

## Interface
- DATA_WIDTH, 64, HWDATA/HRDATA width (32, 64 or 128)
- ADDR_WIDTH, 32, HADDR width
- MEM_DEPTH, 1024, memory depth in DATA_WIDTH words (power of 2)
- STALL_RATE, 0, stall threshold 0..256 (probability STALL_RATE/256)
- MAX_WAIT, 3, maximum wait states per stalled transfer (1..15)
- ERR_BASE, 32'hF000_0000, base of the error window
- ERR_MASK, 32'hF000_0000, error window match mask
- LFSR_SEED, 16'hACE1, LFSR reset value (non-zero)

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL  in  1  slave select
- HADDR  in  ADDR_WIDTH  address
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type (informational only)
- HWDATA  in  DATA_WIDTH  write data
- stall_en  in  1  wait-state injection enable
- HREADY  out  1  transfer done / slave ready
- HRDATA  out  DATA_WIDTH  read data
- HRESP  out  1  0 = OKAY, 1 = ERROR
- xfer_count  out  16  completed OKAY transfers, saturating
- err_count  out  16  completed ERROR transfers, saturating

## Operation
- Address phase is accepted when HSEL && HTRANS[1] && HREADY. On acceptance, capture addr, write, size and err flags.
- err flag is set when any of these holds:
  - (HADDR & ERR_MASK) == ERR_BASE
  - 2**HSIZE > DATA_WIDTH/8
  - HADDR is not aligned to 2**HSIZE
- IDLE or BUSY transfers, and unselected cycles: zero-wait OKAY. Counters are not touched.
- FSM states:
  - S_IDLE: HREADY=1, HRESP=0.
  - S_WAIT: HREADY=0, HRESP=0; wait counter decrements.
  - S_DATA: HREADY=1, HRESP=0; transfer completes.
  - S_ERR1: HREADY=0, HRESP=1.
  - S_ERR2: HREADY=1, HRESP=1.
- Transitions on acceptance:
  - err → S_ERR1 → S_ERR2. An error transfer never gets wait states.
  - Otherwise, if stall_en && lfsr[7:0] < STALL_RATE → S_WAIT with wait_cnt = (lfsr[15:8] % MAX_WAIT) + 1.
  - Otherwise → S_DATA.
- S_WAIT → S_DATA when wait_cnt reaches 1. S_DATA and S_ERR2 go to S_WAIT, S_ERR1 or S_DATA if a new transfer is accepted in the same cycle, else to S_IDLE.
- Memory index = addr[log2(DATA_WIDTH/8)+log2(MEM_DEPTH)-1 : log2(DATA_WIDTH/8)]. Higher address bits are ignored, so the address wraps modulo the memory size.
- Byte lanes: lane i is active when addr_low <= i < addr_low + 2**size, where addr_low = addr mod (DATA_WIDTH/8).
- Write: active lanes of HWDATA are written into memory at the rising edge ending S_DATA. ERROR writes never modify memory.
- Read: in S_DATA, HRDATA carries memory data on active lanes and 0 on inactive lanes. In all other states HRDATA = 0.
- Counters increment at completion: xfer_count at S_DATA with HREADY, err_count at S_ERR2. Both saturate at 16'hFFFF.
- Reset values: state S_IDLE, HREADY=1, HRESP=0, HRDATA=0, counters 0, lfsr=LFSR_SEED. Memory contents are not reset.
- Reset mid-transfer: the pending transfer is abandoned and no memory write is committed.

## Timing
- Zero-wait transfer: data phase lasts 1 cycle, immediately after the address phase.
- Stalled transfer: data phase lasts wait_cnt+1 cycles.
- Error transfer: exactly 2 cycles (HRESP=1 in both, HREADY low then high).
- LFSR is 16-bit Fibonacci, taps 16,14,13,11, and advances every cycle out of reset.
- Back-to-back write then read of the same word: the write commits at the end of its data phase, before the read's data phase, so the read returns the new data. No forwarding is needed.
- The next address phase may overlap the S_DATA or S_ERR2 cycle. It is never accepted during S_WAIT or S_ERR1 (HREADY=0).

## Structure
- The shared package ahb_pkg holds htrans_t, hburst_t, hsize_t and resp_t, plus a new slv_state_t (S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2).
- Sub-module ahb_lfsr16 has parameter SEED and ports clk, rst_n, out[15:0]. It is reusable by other bus models.
- Memory is an unpacked array inside ahb_mem_slave, with a per-lane write enable.

## Test plan
- Reset, then idle: HREADY=1, HRESP=0, HRDATA=0, both counters 0.
- Word write 64'h0123_4567_89AB_CDEF to 0x100, then word read of 0x100, STALL_RATE=0: each data phase is 1 cycle; read returns the same value; xfer_count=2.
- Byte write 8'h5A at 0x103, then read 0x103 with HSIZE=byte: HRDATA[31:24]=8'h5A, all other lanes 0.
- Write to 0xF000_0010: HRESP=1 for 2 cycles with HREADY 0 then 1. A later read of index 2 is unchanged. err_count=1.
- Halfword access at 0x101: ERROR response; memory untouched.
- STALL_RATE=256, MAX_WAIT=3, 100 reads: every transfer has 1–3 wait states; the sequence matches a golden LFSR model seeded with 16'hACE1; xfer_count=100.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the axi2ahb bus models.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HALF  = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011,
        HSIZE_128   = 3'b100,
        HSIZE_256   = 3'b101,
        HSIZE_512   = 3'b110,
        HSIZE_1024  = 3'b111
    } hsize_t;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } resp_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } slv_state_t;

    // Saturating increment for the 16-bit scoreboard counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ahb_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1), advancing every cycle.
module ahb_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] out
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    assign out = r_lfsr;

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory-backed slave with byte lanes, LFSR wait states,
// error window / size / alignment errors and completion counters.
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           MEM_DEPTH  = 1024,
    parameter int unsigned           STALL_RATE = 0,
    parameter int unsigned           MAX_WAIT   = 3,
    parameter logic [ADDR_WIDTH-1:0] ERR_BASE   = ADDR_WIDTH'(32'hF000_0000),
    parameter logic [ADDR_WIDTH-1:0] ERR_MASK   = ADDR_WIDTH'(32'hF000_0000),
    parameter logic [15:0]           LFSR_SEED  = 16'hACE1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  stall_en,
    output logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HRESP,
    output logic [15:0]           xfer_count,
    output logic [15:0]           err_count
);

    localparam int unsigned BYTES      = DATA_WIDTH / 8;
    localparam int unsigned LOG2_BYTES = $clog2(BYTES);
    localparam int unsigned LOG2_DEPTH = $clog2(MEM_DEPTH);

    slv_state_t            r_state;
    logic                  r_hready;
    logic                  r_hresp;
    logic                  r_write;
    logic [LOG2_DEPTH-1:0] r_idx;
    logic [BYTES-1:0]      r_lane;
    logic [3:0]            r_wait_cnt;
    logic [15:0]           r_xfer;
    logic [15:0]           r_err;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [15:0]           w_lfsr;
    logic                  w_accept;
    logic                  w_err;
    logic                  w_stall;
    logic [LOG2_BYTES-1:0] w_addr_low;
    logic [6:0]            w_align_mask;
    logic [3:0]            w_wait_init;
    logic [BYTES-1:0]      w_lane;
    logic [DATA_WIDTH-1:0] w_bit_mask;
    logic                  w_unused;

    assign w_unused = ^{HTRANS[0], HBURST};

    ahb_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .out   (w_lfsr)
    );

    // Address-phase decode: acceptance, error classification, stall decision.
    assign w_accept     = HSEL && HTRANS[1] && r_hready;
    assign w_addr_low   = HADDR[LOG2_BYTES-1:0];
    assign w_align_mask = 7'((8'd1 << HSIZE) - 8'd1);
    assign w_err        = ((HADDR & ERR_MASK) == ERR_BASE)
                       || (HSIZE > 3'(LOG2_BYTES))
                       || (|(HADDR[6:0] & w_align_mask));
    assign w_stall      = stall_en && ({1'b0, w_lfsr[7:0]} < 9'(STALL_RATE));
    assign w_wait_init  = 4'((32'(w_lfsr[15:8]) % MAX_WAIT) + 32'd1);

    always_comb begin
        w_lane = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if ((i >= 32'(w_addr_low)) && (i < 32'(w_addr_low) + (32'd1 << HSIZE))) begin
                w_lane[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_bit_mask = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            w_bit_mask[i*8 +: 8] = {8{r_lane[i]}};
        end
    end

    // Transfer FSM with registered HREADY/HRESP and completion counters.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= S_IDLE;
            r_hready   <= 1'b1;
            r_hresp    <= 1'b0;
            r_write    <= 1'b0;
            r_idx      <= '0;
            r_lane     <= '0;
            r_wait_cnt <= '0;
            r_xfer     <= '0;
            r_err      <= '0;
        end else begin
            if (r_state == S_DATA) begin
                r_xfer <= sat_inc16(r_xfer);
            end
            if (r_state == S_ERR2) begin
                r_err <= sat_inc16(r_err);
            end

            case (r_state)
                S_WAIT: begin
                    if (r_wait_cnt == 4'd1) begin
                        r_state  <= S_DATA;
                        r_hready <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    r_state  <= S_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b1;
                end
                default: begin
                    if (w_accept) begin
                        r_write <= HWRITE;
                        r_idx   <= HADDR[LOG2_BYTES +: LOG2_DEPTH];
                        r_lane  <= w_lane;
                        if (w_err) begin
                            r_state  <= S_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b1;
                        end else if (w_stall) begin
                            r_state    <= S_WAIT;
                            r_hready   <= 1'b0;
                            r_hresp    <= 1'b0;
                            r_wait_cnt <= w_wait_init;
                        end else begin
                            r_state  <= S_DATA;
                            r_hready <= 1'b1;
                            r_hresp  <= 1'b0;
                        end
                    end else begin
                        r_state  <= S_IDLE;
                        r_hready <= 1'b1;
                        r_hresp  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Write commits on the edge that ends S_DATA; reset leaves contents intact.
    always_ff @(posedge HCLK) begin
        if ((r_state == S_DATA) && r_write) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (r_lane[i]) begin
                    r_mem[r_idx][i*8 +: 8] <= HWDATA[i*8 +: 8];
                end
            end
        end
    end

    assign HRDATA     = (r_state == S_DATA) ? (r_mem[r_idx] & w_bit_mask) : '0;
    assign HREADY     = r_hready;
    assign HRESP      = r_hresp;
    assign xfer_count = r_xfer;
    assign err_count  = r_err;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Scoreboard bench for ahb_mem_slave: driver pushes expected responses,
// negedge monitor pops and checks each completed data phase.
module tb_ahb_mem_slave;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [63:0] HWDATA;
    logic        stall_en;
    logic        HREADY;
    logic [63:0] HRDATA;
    logic        HRESP;
    logic [15:0] xfer_count;
    logic [15:0] err_count;

    ahb_mem_slave #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (32),
        .MEM_DEPTH  (1024),
        .STALL_RATE (256),
        .MAX_WAIT   (3),
        .ERR_BASE   (32'hF000_0000),
        .ERR_MASK   (32'hF000_0000),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HWDATA     (HWDATA),
        .stall_en   (stall_en),
        .HREADY     (HREADY),
        .HRDATA     (HRDATA),
        .HRESP      (HRESP),
        .xfer_count (xfer_count),
        .err_count  (err_count)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        string       nm;
        bit          err;
        bit          chk;
        logic [63:0] rdata;
        int          wt;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          in_data = 1'b0;
    int          low_cyc = 0;
    logic [15:0] tb_lfsr;

    localparam logic [63:0] W100 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W100B = 64'h0123_4567_5AAB_CDEF;
    localparam logic [63:0] W010 = 64'hDEAD_BEEF_CAFE_F00D;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Golden LFSR: x^16+x^14+x^13+x^11+1, seeded on reset, steps every cycle.
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) tb_lfsr <= 16'hACE1;
        else          tb_lfsr <= {tb_lfsr[14:0], tb_lfsr[15] ^ tb_lfsr[13] ^ tb_lfsr[12] ^ tb_lfsr[10]};
    end

    // Monitor: one data phase at a time, completion when HREADY is high.
    always @(negedge HCLK) begin
        exp_t e;
        if (!HRESETn) begin
            in_data = 1'b0;
            sb.delete();
        end else begin
            if (in_data) begin
                if (!HREADY) begin
                    low_cyc++;
                    check("wait_rdata", HRDATA, 64'h0);
                    if (sb.size() > 0) check({sb[0].nm, "_wait_resp"}, 64'(HRESP), 64'(sb[0].err));
                end else begin
                    if (sb.size() == 0) begin
                        check("sb_empty", 64'(1), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        check({e.nm, "_resp"}, 64'(HRESP), 64'(e.err));
                        check({e.nm, "_waits"}, 64'(low_cyc), 64'(e.wt));
                        if (e.err)      check({e.nm, "_rdata"}, HRDATA, 64'h0);
                        else if (e.chk) check({e.nm, "_rdata"}, HRDATA, e.rdata);
                    end
                    in_data = 1'b0;
                end
            end else begin
                check("idle_bus", {HRDATA[61:0], HREADY, HRESP}, {62'h0, 1'b1, 1'b0});
            end
            if (HSEL && HTRANS[1] && HREADY) begin
                in_data = 1'b1;
                low_cyc = 0;
            end
        end
    end

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 3'd3;
    endtask

    // Issue one transfer; returns one cycle after acceptance with HWDATA driven.
    task automatic xfer(input string nm, input logic [31:0] addr, input bit wr, input logic [2:0] size,
                        input logic [63:0] wdata, input bit err, input logic [63:0] rdata);
        exp_t e;
        bit   acc = 1'b0;
        HSEL   = 1'b1;
        HADDR  = addr;
        HTRANS = 2'b10;
        HWRITE = wr;
        HSIZE  = size;
        HBURST = 3'b000;
        for (int k = 0; k < 40; k++) begin
            @(negedge HCLK);
            if (HREADY) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            check({nm, "_accept_timeout"}, 64'(0), 64'(1));
        end else begin
            e.nm    = nm;
            e.err   = err;
            e.chk   = !wr;
            e.rdata = rdata;
            e.wt    = err ? 1 : (stall_en ? int'(tb_lfsr[15:8] % 8'd3) + 1 : 0);
            sb.push_back(e);
        end
        @(posedge HCLK);
        #1;
        HWDATA = wdata;
        bus_idle();
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge HCLK);
            if (sb.size() == 0 && !in_data) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", 64'(0), 64'(1));
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        HRESETn  = 1'b0;
        HWDATA   = '0;
        HADDR    = '0;
        HBURST   = 3'b000;
        stall_en = 1'b0;
        bus_idle();
        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        @(negedge HCLK);
        check("rst_hready", 64'(HREADY), 64'(1));
        check("rst_hresp", 64'(HRESP), 64'(0));
        check("rst_hrdata", HRDATA, 64'h0);
        check("rst_xfer", 64'(xfer_count), 64'(0));
        check("rst_err", 64'(err_count), 64'(0));
        @(posedge HCLK);
        #1;

        xfer("wr100", 32'h100, 1'b1, 3'd3, W100, 1'b0, 64'h0);
        xfer("rd100", 32'h100, 1'b0, 3'd3, 64'h0, 1'b0, W100);
        drain();
        check("xfer_after_wr_rd", 64'(xfer_count), 64'(2));

        xfer("wrbyte", 32'h103, 1'b1, 3'd0, 64'hFFFF_FFFF_5AFF_FFFF, 1'b0, 64'h0);
        xfer("rdbyte", 32'h103, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0000_0000_5A00_0000);
        xfer("rd100b", 32'h100, 1'b0, 3'd3, 64'h0, 1'b0, W100B);
        xfer("wr010", 32'h10, 1'b1, 3'd3, W010, 1'b0, 64'h0);
        xfer("errwin", 32'hF000_0010, 1'b1, 3'd3, 64'h1111_2222_3333_4444, 1'b1, 64'h0);
        xfer("rd010", 32'h10, 1'b0, 3'd3, 64'h0, 1'b0, W010);
        drain();
        check("err_after_window", 64'(err_count), 64'(1));

        xfer("errhalf", 32'h101, 1'b1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0);
        xfer("rd100c", 32'h100, 1'b0, 3'd3, 64'h0, 1'b0, W100B);
        xfer("errsize", 32'h100, 1'b0, 3'd4, 64'h0, 1'b1, 64'h0);
        drain();
        check("xfer_total", 64'(xfer_count), 64'(8));
        check("err_total", 64'(err_count), 64'(3));

        // Reset during a stalled write: nothing committed, counters cleared.
        stall_en = 1'b1;
        HSEL   = 1'b1;
        HADDR  = 32'h10;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HSIZE  = 3'd3;
        @(posedge HCLK);
        #1;
        HWDATA = 64'h5555_6666_7777_8888;
        bus_idle();
        @(negedge HCLK);
        check("mid_rst_stalled", 64'(HREADY), 64'(0));
        #1;
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn  = 1'b1;
        stall_en = 1'b0;
        check("mid_rst_xfer", 64'(xfer_count), 64'(0));
        xfer("rd010_post_rst", 32'h10, 1'b0, 3'd3, 64'h0, 1'b0, W010);
        drain();
        check("xfer_post_rst", 64'(xfer_count), 64'(1));
        check("err_post_rst", 64'(err_count), 64'(0));

        // Stall section from a fresh LFSR seed.
        do_reset();
        stall_en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (n % 2 == 0) xfer("stall_rd100", 32'h100, 1'b0, 3'd3, 64'h0, 1'b0, W100B);
            else            xfer("stall_rd010", 32'h10, 1'b0, 3'd3, 64'h0, 1'b0, W010);
        end
        drain();
        check("xfer_stall_100", 64'(xfer_count), 64'(100));
        check("err_stall_100", 64'(err_count), 64'(0));
        stall_en = 1'b0;
        repeat (2) @(posedge HCLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
